// File: rtl/main_mem_arb_if.sv
// Port bundle between the address generators, the main-memory arbiter and the SRAM macro.
// slave = arbiter side, master = requester/memory side.
interface main_mem_arb_if #(
  parameter int WID     = 6,
  parameter int AW      = 18,
  parameter int WBUF_AW = 3
);
  logic               wr_req;
  logic [AW-1:0]      wr_addr;
  logic [WID-1:0]     wr_data;
  logic               wr_full;
  logic [WBUF_AW:0]   wbuf_level;
  logic               ovf_err;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic               rd_gnt;
  logic               rd_dv;
  logic [WID-1:0]     rd_data;
  logic [15:0]        rd_stall_cnt;
  logic               mem_en;
  logic               mem_wr;
  logic [AW-1:0]      mem_addr;
  logic [WID-1:0]     mem_din;
  logic [WID-1:0]     mem_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout,
    output wr_full, wbuf_level, ovf_err, rd_gnt, rd_dv, rd_data, rd_stall_cnt,
           mem_en, mem_wr, mem_addr, mem_din
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout,
    input  wr_full, wbuf_level, ovf_err, rd_gnt, rd_dv, rd_data, rd_stall_cnt,
           mem_en, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/main_mem_arb.sv
// Single-port main-memory arbiter: buffered write stream vs. LDPC reads, fixed 3-cycle read latency.
// Optional read-stall statistic counter enabled by MAIN_MEM_ARB_STAT_EN.
module main_mem_arb #(
  parameter int WID        = 6,
  parameter int AW         = 18,
  parameter int WBUF_AW    = 3,
  parameter int HI_WM      = 6,
  parameter int LO_WM      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  main_mem_arb_if.slave bus
);
  localparam int DEPTH  = 2**WBUF_AW;
  localparam int LW     = WBUF_AW + 1;
  localparam int SW     = $clog2(STARVE_MAX + 1);
  localparam int RD_LAT = 3;

  typedef enum logic {SERVE, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        level_q, level_d;
  logic [WBUF_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 ovf_q, ovf_d;
  logic                 mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [WID-1:0]       mem_din_q, mem_din_d;
  logic [RD_LAT:1]      vld_pipe_q, vld_pipe_d;
  logic [WID-1:0]       rd_data_q, rd_data_d;

  logic [AW+WID-1:0]    buf_q [DEPTH];
  logic [AW-1:0]        head_addr;
  logic [WID-1:0]       head_data;
  logic                 empty, full, push, pop, gnt;

  assign {head_addr, head_data} = buf_q[rptr_q];
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  always_comb begin
    push       = bus.wr_req & ~full & ~clr;
    gnt        = 1'b0;
    pop        = 1'b0;
    state_d    = state_q;
    starve_d   = starve_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    // Grant decision uses registered state only; clr suppresses both ops.
    if (!clr) begin
      if (state_q == DRAIN) begin
        pop = ~empty;
      end else begin
        gnt = bus.rd_req & (empty | (starve_q < SW'(STARVE_MAX)));
        pop = ~gnt & ~empty;
      end
    end

    level_d = level_q + LW'(push) - LW'(pop);
    wptr_d  = wptr_q + WBUF_AW'(push);
    rptr_d  = rptr_q + WBUF_AW'(pop);
    ovf_d   = ovf_q | (bus.wr_req & full);

    if (pop || empty)  starve_d = '0;
    else if (gnt)      starve_d = starve_q + SW'(1);

    if (state_q == SERVE && level_d >= LW'(HI_WM))      state_d = DRAIN;
    else if (state_q == DRAIN && level_d <= LW'(LO_WM)) state_d = SERVE;

    if (clr) begin
      level_d  = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      ovf_d    = 1'b0;
      starve_d = '0;
      state_d  = SERVE;
    end

    mem_en_d = gnt | pop;
    mem_wr_d = pop;
    if (gnt) begin
      mem_addr_d = bus.rd_addr;
    end else if (pop) begin
      mem_addr_d = head_addr;
      mem_din_d  = head_data;
    end

    // In-flight reads are not affected by clr.
    vld_pipe_d = {vld_pipe_q[RD_LAT-1:1], gnt};
    rd_data_d  = vld_pipe_q[RD_LAT-1] ? bus.mem_dout : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SERVE;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      starve_q   <= '0;
      ovf_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      vld_pipe_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      starve_q   <= starve_d;
      ovf_q      <= ovf_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      vld_pipe_q <= vld_pipe_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Buffer storage needs no reset: occupancy is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= {bus.wr_addr, bus.wr_data};
  end

`ifdef MAIN_MEM_ARB_STAT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clr)                                          stall_d = '0;
    else if (bus.rd_req && !gnt && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.rd_stall_cnt = stall_q;
`else
  assign bus.rd_stall_cnt = '0;
`endif

  assign bus.wr_full    = full;
  assign bus.wbuf_level = level_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.rd_gnt     = gnt;
  assign bus.rd_dv      = vld_pipe_q[RD_LAT];
  assign bus.rd_data    = rd_data_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
endmodule

// File: tb/tb_main_mem_arb.sv
// Bench for main_mem_arb: two instances (HI_WM 6 and 8) share one stimulus stream and are
// checked every cycle against a queue-level model, plus hand-computed literal expectations.
module tb_main_mem_arb;
  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        wr_req, rd_req;
  logic [17:0] wr_addr, rd_addr;
  logic [5:0]  wr_data;

  int n_chk = 0;
  int n_err = 0;

  main_mem_arb_if #(.WID(6), .AW(18), .WBUF_AW(3)) b0();
  main_mem_arb_if #(.WID(6), .AW(18), .WBUF_AW(3)) b1();

  assign b0.wr_req = wr_req;  assign b1.wr_req = wr_req;
  assign b0.wr_addr = wr_addr; assign b1.wr_addr = wr_addr;
  assign b0.wr_data = wr_data; assign b1.wr_data = wr_data;
  assign b0.rd_req = rd_req;  assign b1.rd_req = rd_req;
  assign b0.rd_addr = rd_addr; assign b1.rd_addr = rd_addr;

  main_mem_arb u_dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b0));
  main_mem_arb #(.HI_WM(8)) u_ovf (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b1));

  always #5 clk = ~clk;

  // SRAM stand-ins: a read returns addr[5:0] one cycle after the strobe.
  always @(posedge clk) if (b0.mem_en && !b0.mem_wr) b0.mem_dout <= b0.mem_addr[5:0];
  always @(posedge clk) if (b1.mem_en && !b1.mem_wr) b1.mem_dout <= b1.mem_addr[5:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef logic [23:0] ent_t;
  ent_t        fq [2][8];
  int          cnt [2], starve [2], stall [2], rn [2];
  bit          drain [2], ovf [2], e_en [2], e_wr [2], e_dv [2];
  logic [17:0] e_addr [2];
  logic [5:0]  e_din [2], e_rdata [2];
  int          rdue [2][4];
  logic [5:0]  rval [2][4];
  int          cyc = 0;

  function automatic bit dec_gnt(int k);
    if (clr || drain[k]) return 1'b0;
    return rd_req && (cnt[k] == 0 || starve[k] < 4);
  endfunction

  function automatic bit dec_pop(int k);
    if (clr) return 1'b0;
    if (drain[k]) return cnt[k] > 0;
    return !dec_gnt(k) && cnt[k] > 0;
  endfunction

  task automatic m_reset(int k);
    cnt[k] = 0; starve[k] = 0; stall[k] = 0; rn[k] = 0;
    drain[k] = 0; ovf[k] = 0; e_en[k] = 0; e_wr[k] = 0; e_dv[k] = 0;
    e_addr[k] = '0; e_din[k] = '0; e_rdata[k] = '0;
  endtask

  task automatic m_step(int k);
    int hi = (k == 0) ? 6 : 8;
    bit g = dec_gnt(k);
    bit p = dec_pop(k);
    bit full = (cnt[k] == 8);
    bit push = wr_req && !full && !clr;
    if (g) begin
      e_en[k] = 1; e_wr[k] = 0; e_addr[k] = rd_addr;
      rdue[k][rn[k]] = cyc + 3; rval[k][rn[k]] = rd_addr[5:0]; rn[k]++;
    end else if (p) begin
      e_en[k] = 1; e_wr[k] = 1; {e_addr[k], e_din[k]} = fq[k][0];
    end else begin
      e_en[k] = 0;
    end
    if (clr || p || cnt[k] == 0) starve[k] = 0;
    else if (g)                  starve[k]++;
    if (clr) stall[k] = 0;
    else if (rd_req && !g && stall[k] < 65535) stall[k]++;
    ovf[k] = clr ? 1'b0 : (ovf[k] | (wr_req && full));
    if (p) begin
      for (int i = 0; i < 7; i++) fq[k][i] = fq[k][i+1];
      cnt[k]--;
    end
    if (push) begin fq[k][cnt[k]] = {wr_addr, wr_data}; cnt[k]++; end
    if (clr) begin cnt[k] = 0; drain[k] = 0; end
    else if (!drain[k] && cnt[k] >= hi) drain[k] = 1;
    else if (drain[k] && cnt[k] <= 2)   drain[k] = 0;
  endtask

  task automatic m_adv(int k);
    e_dv[k] = (rn[k] > 0) && (rdue[k][0] == cyc);
    if (e_dv[k]) begin
      e_rdata[k] = rval[k][0];
      for (int i = 0; i < 3; i++) begin rdue[k][i] = rdue[k][i+1]; rval[k][i] = rval[k][i+1]; end
      rn[k]--;
    end
  endtask

  task automatic cmp_inst(input int k, input logic gnt, full, input logic [3:0] lvl,
                          input logic ov, en, wr, input logic [17:0] addr, input logic [5:0] din,
                          input logic dv, input logic [5:0] rdata, input logic [15:0] st);
    string p = $sformatf("c%0d u%0d.", cyc, k);
    int est;
`ifdef MAIN_MEM_ARB_STAT_EN
    est = stall[k];
`else
    est = 0;
`endif
    chk({p, "rd_gnt"}, gnt, dec_gnt(k));
    chk({p, "wr_full"}, full, cnt[k] == 8);
    chk({p, "wbuf_level"}, lvl, cnt[k]);
    chk({p, "ovf_err"}, ov, ovf[k]);
    chk({p, "mem_en"}, en, e_en[k]);
    if (e_en[k]) chk({p, "mem_wr"}, wr, e_wr[k]);
    chk({p, "mem_addr"}, addr, e_addr[k]);
    chk({p, "mem_din"}, din, e_din[k]);
    chk({p, "rd_dv"}, dv, e_dv[k]);
    chk({p, "rd_data"}, rdata, e_rdata[k]);
    chk({p, "rd_stall_cnt"}, st, est);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin m_reset(0); m_reset(1); end
    cmp_inst(0, b0.rd_gnt, b0.wr_full, b0.wbuf_level, b0.ovf_err, b0.mem_en, b0.mem_wr,
             b0.mem_addr, b0.mem_din, b0.rd_dv, b0.rd_data, b0.rd_stall_cnt);
    cmp_inst(1, b1.rd_gnt, b1.wr_full, b1.wbuf_level, b1.ovf_err, b1.mem_en, b1.mem_wr,
             b1.mem_addr, b1.mem_din, b1.rd_dv, b1.rd_data, b1.rd_stall_cnt);
    if (rst_n) begin
      m_step(0); m_step(1);
      cyc++;
      m_adv(0); m_adv(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    wr_req = 0; rd_req = 0; clr = 0;
    repeat (n) nxt();
  endtask

  task automatic do_clr();
    wr_req = 0; rd_req = 0; clr = 1;
    nxt();
    clr = 0;
  endtask

  initial begin
    rst_n = 0; clr = 0; wr_req = 0; rd_req = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset level", b0.wbuf_level, 0);
    chk("reset mem_en", b0.mem_en, 0);
    chk("reset ovf_err", b0.ovf_err, 0);
    chk("reset rd_dv", b0.rd_dv, 0);

    // Writes only: push addr c in cycle c, written to memory in cycle c+2.
    for (int c = 0; c < 8; c++) begin
      wr_req = (c < 5); wr_addr = 18'(c); wr_data = 6'(c + 1);
      if (c >= 2 && c <= 6) begin
        chk($sformatf("wr%0d mem_en", c), b0.mem_en, 1);
        chk($sformatf("wr%0d mem_wr", c), b0.mem_wr, 1);
        chk($sformatf("wr%0d mem_addr", c), b0.mem_addr, c - 2);
        chk($sformatf("wr%0d mem_din", c), b0.mem_din, c - 1);
      end
      nxt();
    end
    chk("wr level drained", b0.wbuf_level, 0);
    chk("wr ovf_err", b0.ovf_err, 0);

    // Single read: grant now, strobe next cycle, data three cycles after grant.
    rd_req = 1; rd_addr = 18'd138240;
    #1 chk("rd gnt", b0.rd_gnt, 1);
    nxt();
    rd_req = 0;
    chk("rd mem_en", b0.mem_en, 1);
    chk("rd mem_wr", b0.mem_wr, 0);
    chk("rd mem_addr", b0.mem_addr, 138240);
    nxt(); nxt();
    chk("rd dv", b0.rd_dv, 1);
    chk("rd data", b0.rd_data, 0);

    // Back-to-back reads with distinct data.
    for (int c = 0; c < 3; c++) begin
      rd_req = 1; rd_addr = 18'(1000 + 7 * c);
      nxt();
    end
    idle(5);

    // Starvation: 3 writes interleaved with held reads, R x4 then W.
    for (int c = 0; c < 21; c++) begin
      rd_req = 1; rd_addr = 18'h00A2B;
      wr_req = (c < 3); wr_addr = 18'(200 + c); wr_data = 6'(10 + c);
      nxt();
    end
    chk("starve level drained", b0.wbuf_level, 0);
    idle(4);

    // Drain: 7 pushes under held reads reach level 6 at cycle 6.
    do_clr();
    for (int c = 0; c < 12; c++) begin
      rd_req = 1; rd_addr = 18'h01234;
      wr_req = (c < 7); wr_addr = 18'(300 + c); wr_data = 6'(20 + c);
      #1;
      if (c == 7)  chk("drain gnt off", b0.rd_gnt, 0);
      if (c == 10) chk("drain last pop level", b0.wbuf_level, 3);
      if (c == 11) begin
        chk("drain gnt resumes", b0.rd_gnt, 1);
        chk("drain exit level", b0.wbuf_level, 2);
`ifdef MAIN_MEM_ARB_STAT_EN
        chk("drain stall cnt", b0.rd_stall_cnt, 5);
`else
        chk("stall cnt tied", b0.rd_stall_cnt, 0);
`endif
      end
      nxt();
    end
    idle(12);

    // Overflow on the HI_WM=8 instance, then clear.
    do_clr();
    for (int c = 0; c < 13; c++) begin
      rd_req = 1; rd_addr = 18'h02345;
      wr_req = 1; wr_addr = 18'(400 + c); wr_data = 6'(c);
      if (c == 9) begin
        chk("ovf wr_full", b1.wr_full, 1);
        chk("ovf not yet", b1.ovf_err, 0);
      end
      if (c == 10) chk("ovf set", b1.ovf_err, 1);
      nxt();
    end
    clr = 1; rd_req = 0; wr_req = 1;
    nxt();
    clr = 0; wr_req = 0;
    chk("clr level", b1.wbuf_level, 0);
    chk("clr ovf_err", b1.ovf_err, 0);
    chk("clr level u0", b0.wbuf_level, 0);
    idle(5);

    // Reset in the middle of a read: the read never completes.
    rd_req = 1; rd_addr = 18'h0003F;
    nxt();
    rd_req = 0;
    #1 rst_n = 0;
    #1;
    chk("rst rd_dv", b0.rd_dv, 0);
    chk("rst mem_en", b0.mem_en, 0);
    chk("rst mem_addr", b0.mem_addr, 0);
    nxt(); nxt();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("post-rst rd_dv %0d", c), b0.rd_dv, 0);
      nxt();
    end
    rd_req = 1; rd_addr = 18'h00015;
    nxt();
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
